// File: rtl/sram_rw_ctrl_pkg.sv
// Shared types and default geometry for the SRAM read/write controller.
// The FSM has an init sweep phase followed by normal request service.
package sram_rw_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 8192;
  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_AW    = 13;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Highest entry index for a given depth, sized to the address bus.
  function automatic logic [DEFAULT_AW-1:0] last_addr(input int depth);
    return DEFAULT_AW'(depth - 1);
  endfunction

endpackage

// File: rtl/sram_resp_buf.sv
// Read response path: one-cycle bypass of SRAM read data, plus a hold register
// that captures the data when the consumer stalls so resp_rdata stays stable.
module sram_resp_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rd_fire,
  input  logic [WIDTH-1:0] sram_rdata,
  input  logic             resp_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_stall
);

  logic             pend_reg, pend_next;
  logic             held_reg, held_next;
  logic [WIDTH-1:0] hold_reg, hold_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg <= 1'b0;
      held_reg <= 1'b0;
      hold_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      held_reg <= held_next;
      hold_reg <= hold_next;
    end
  end

  // sram_rdata is only sampled in the cycle right after a read enable.
  always_comb begin
    pend_next = rd_fire;
    held_next = held_reg;
    hold_next = hold_reg;
    if (pend_reg && !resp_ready) begin
      held_next = 1'b1;
      hold_next = sram_rdata;
    end else if (held_reg && resp_ready) begin
      held_next = 1'b0;
    end
  end

  assign resp_valid = pend_reg | held_reg;
  assign resp_rdata = held_reg ? hold_reg : sram_rdata;
  assign resp_stall = resp_valid & ~resp_ready;

endmodule

// File: rtl/sram_rw_ctrl.sv
// Single-port SRAM controller: sweeps INIT_VAL into every entry after reset,
// then serves read/write requests with one-cycle read latency.
module sram_rw_ctrl
  import sram_rw_ctrl_pkg::*;
#(
  parameter int               DEPTH    = DEFAULT_DEPTH,
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               AW       = DEFAULT_AW,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             sram_en,
  output logic             sram_wmode,
  output logic [AW-1:0]    sram_addr,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata,
  output logic             init_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] count_reg, count_next;
  logic          req_fire;
  logic          rd_fire;
  logic          resp_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= INIT;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (state_reg == INIT) begin
      count_next = count_reg + AW'(1);
      if (count_reg == LAST_ADDR) begin
        state_next = RUN;
        count_next = '0;
      end
    end
  end

  assign init_done = (state_reg == RUN);

  // Writes never wait; reads wait only while a response is stalled.
  always_comb begin
    req_ready = 1'b0;
    if (state_reg == RUN) begin
      req_ready = req_write | ~resp_stall;
    end
  end

  assign req_fire = req_valid & req_ready;
  assign rd_fire  = req_fire & ~req_write;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_reg)
      INIT: begin
        // Keep the SRAM idle for as long as reset is held.
        sram_en    = reset_n;
        sram_wmode = 1'b1;
        sram_addr  = count_reg;
        sram_wdata = INIT_VAL;
      end
      RUN: begin
        if (req_fire) begin
          sram_en    = 1'b1;
          sram_wmode = req_write;
          sram_addr  = req_addr;
          sram_wdata = req_wdata;
        end
      end
      default: begin
        sram_en = 1'b0;
      end
    endcase
  end

  sram_resp_buf #(
    .WIDTH(WIDTH)
  ) u_resp_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_fire    (rd_fire),
    .sram_rdata (sram_rdata),
    .resp_ready (resp_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_stall (resp_stall)
  );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl with a behavioural single-port SRAM that
// returns junk on any cycle not following a read enable.
module tb_sram_rw_ctrl;

  localparam int DEPTH = 8192;
  localparam int WIDTH = 64;
  localparam int AW    = 13;
  localparam logic [WIDTH-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_rdata;
  logic             sram_en;
  logic             sram_wmode;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_wdata;
  logic [WIDTH-1:0] sram_rdata = JUNK;
  logic             init_done;

  logic [WIDTH-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sram_rw_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .init_done  (init_done)
  );

  // Behavioural SRAM: registered read, output is junk unless a read was issued.
  always @(posedge clock) begin
    if (sram_en && !sram_wmode) begin
      sram_rdata <= mem[sram_addr];
    end else begin
      sram_rdata <= JUNK;
    end
    if (sram_en && sram_wmode) begin
      mem[sram_addr] = sram_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at the negedge right after reset release; returns at the first negedge with init_done.
  task automatic run_sweep(input string tag);
    int k;
    int bad;
    k = 0;
    bad = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 13'h0ABC;
    req_wdata = 64'h1111_2222_3333_4444;
    while (init_done !== 1'b1 && k < 9000) begin
      #1;
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== AW'(k) ||
          sram_wdata !== '0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        bad++;
      end
      @(posedge clock);
      @(negedge clock);
      k++;
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    chk({tag, "_sweep_errs"}, 64'(bad), 64'd0);
    chk({tag, "_init_latency"}, 64'(k), 64'(DEPTH));
  endtask

  typedef struct {
    logic             valid;
    logic             write;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic             rready;
    logic             exp_ready;
    logic             exp_rvalid;
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_en;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                              input logic [WIDTH-1:0] d, input logic rr, input logic er,
                              input logic ev, input logic [WIDTH-1:0] ed, input logic ee);
    vec_t t;
    t.valid = v; t.write = w; t.addr = a; t.wdata = d; t.rready = rr;
    t.exp_ready = er; t.exp_rvalid = ev; t.exp_rdata = ed; t.exp_en = ee;
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'(i * 3 + 1)};
  endfunction

  localparam logic [WIDTH-1:0] D1 = 64'hDEADBEEF_00000001;
  localparam logic [WIDTH-1:0] D2 = 64'h0000_0000_0000_1234;
  localparam logic [WIDTH-1:0] D3 = 64'h0000_0000_0000_CAFE;

  vec_t vecs [21];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;

    //                 v     w     addr      wdata  rr    ready rvalid rdata en
    vecs[0]  = mk(1'b1, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 13'd8191, '0, 1'b1, 1'b1, 1'b1, '0, 1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b1, '0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 13'd5,    D1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    vecs[4]  = mk(1'b1, 1'b0, 13'd5,    '0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b1, D1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 13'd5,    '0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    vecs[7]  = mk(1'b1, 1'b1, 13'd5,    D2, 1'b0, 1'b1, 1'b1, D1, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 13'd7,    '0, 1'b0, 1'b0, 1'b1, D1, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 13'd7,    '0, 1'b0, 1'b0, 1'b1, D1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 13'd7,    '0, 1'b0, 1'b0, 1'b1, D1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b1, D1, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 13'd5,    '0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b1, D2, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 13'd9,    D3, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    vecs[15] = mk(1'b1, 1'b0, 13'd9,    '0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    vecs[16] = mk(1'b0, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b1, D3, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 13'd9,    '0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, 13'd5,    '0, 1'b0, 1'b0, 1'b1, D3, 1'b0);
    vecs[19] = mk(1'b1, 1'b0, 13'd5,    '0, 1'b1, 1'b1, 1'b1, D3, 1'b1);
    vecs[20] = mk(1'b0, 1'b0, 13'd0,    '0, 1'b1, 1'b1, 1'b1, D2, 1'b0);

    // Power-on reset with a write request pending.
    req_valid = 1'b1;
    req_write = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("por_init_done", 64'(init_done), 64'd0);
    chk("por_req_ready", 64'(req_ready), 64'd0);
    chk("por_resp_valid", 64'(resp_valid), 64'd0);
    chk("por_sram_en", 64'(sram_en), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_sweep("init");

    // Table-driven request/response vectors, one clock each.
    for (int i = 0; i < 21; i++) begin
      req_valid  = vecs[i].valid;
      req_write  = vecs[i].write;
      req_addr   = vecs[i].addr;
      req_wdata  = vecs[i].wdata;
      resp_ready = vecs[i].rready;
      #1;
      $display("vec %0d valid=%0b write=%0b addr=%0d rready=%0b -> ready=%0b rvalid=%0b rdata=%h en=%0b",
               i, req_valid, req_write, req_addr, resp_ready, req_ready, resp_valid, resp_rdata, sram_en);
      chk($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_resp_valid", i), 64'(resp_valid), 64'(vecs[i].exp_rvalid));
      chk($sformatf("vec%0d_sram_en", i), 64'(sram_en), 64'(vecs[i].exp_en));
      if (vecs[i].exp_rvalid) begin
        chk($sformatf("vec%0d_resp_rdata", i), resp_rdata, vecs[i].exp_rdata);
      end
      if (vecs[i].exp_en) begin
        chk($sformatf("vec%0d_sram_addr", i), 64'(sram_addr), 64'(vecs[i].addr));
        chk($sformatf("vec%0d_sram_wmode", i), 64'(sram_wmode), 64'(vecs[i].write));
      end
      @(posedge clock);
      @(negedge clock);
    end

    // Fill 0..15 with distinct patterns, then stream reads back at full rate.
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = AW'(i);
      req_wdata = pat(i);
      #1;
      chk($sformatf("fill%0d_ready", i), 64'(req_ready), 64'd1);
      @(posedge clock);
      @(negedge clock);
    end
    for (int i = 0; i <= 16; i++) begin
      req_valid = (i < 16);
      req_write = 1'b0;
      req_addr  = AW'(i % 16);
      #1;
      if (i < 16) chk($sformatf("stream%0d_ready", i), 64'(req_ready), 64'd1);
      if (i == 0) begin
        chk("stream0_no_resp", 64'(resp_valid), 64'd0);
      end else begin
        chk($sformatf("stream%0d_valid", i), 64'(resp_valid), 64'd1);
        chk($sformatf("stream%0d_rdata", i), resp_rdata, pat(i - 1));
      end
      @(posedge clock);
      @(negedge clock);
    end
    #1;
    chk("stream_drained", 64'(resp_valid), 64'd0);

    // Reset while a response is held.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 13'd5;
    resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("held_valid", 64'(resp_valid), 64'd1);
    chk("held_rdata", resp_rdata, pat(5));
    reset_n = 1'b0;
    #1;
    chk("held_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("held_rst_init_done", 64'(init_done), 64'd0);
    chk("held_rst_sram_en", 64'(sram_en), 64'd0);
    chk("held_rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_sweep("held_rst");
    #1;
    chk("held_rst_dropped", 64'(resp_valid), 64'd0);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 13'd5;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk("post_rst_read_valid", 64'(resp_valid), 64'd1);
    chk("post_rst_read_zero", resp_rdata, 64'd0);
    @(posedge clock);
    @(negedge clock);

    // Reset in the middle of the sweep at address 3000.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    begin
      int k;
      k = 0;
      #1;
      while (sram_addr !== 13'd3000 && k < 4000) begin
        @(posedge clock);
        @(negedge clock);
        #1;
        k++;
      end
      chk("mid_reach_3000", 64'(k), 64'd3000);
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_sram_en", 64'(sram_en), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_init_done", 64'(init_done), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_sweep("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rw_ctrl.md
SRAM_RW_CTRL -- requirements
Module: sram_rw_ctrl

Interface
REQ-001 The block SHALL have parameters: DEPTH, default 8192, number of SRAM entries; WIDTH, default 64, data width; AW, default 13, address width (clog2 DEPTH); INIT_VAL, default 0, value written to every entry during the init sweep.
REQ-002 clock  in  1  single clock for all state; drives the SRAM clock pin externally.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_addr  in  AW  entry index.
REQ-008 req_wdata  in  WIDTH  write data.
REQ-009 resp_valid  out  1  read data present.
REQ-010 resp_ready  in  1  consumer accepts read data.
REQ-011 resp_rdata  out  WIDTH  read data.
REQ-012 sram_en, sram_wmode  out  1 each  SRAM RW-port enable and write mode.
REQ-013 sram_addr  out  AW; sram_wdata  out  WIDTH; sram_rdata  in  WIDTH  (valid only in the cycle after a read enable).
REQ-014 init_done  out  1  high once the init sweep is complete.

Function
REQ-015 The FSM SHALL have states INIT and RUN; reset enters INIT with the sweep counter at 0.
REQ-016 In INIT the block SHALL drive sram_en=1, sram_wmode=1, sram_addr=counter, sram_wdata=INIT_VAL every cycle, increment the counter, and go to RUN after writing address DEPTH-1 (exactly DEPTH cycles).
REQ-017 In INIT req_ready SHALL be 0 and resp_valid SHALL be 0.
REQ-018 In RUN, req_ready SHALL be 1 for writes; for reads it SHALL be 1 unless a response is stalled (resp_valid && !resp_ready).
REQ-019 On an accepted request the block SHALL drive sram_en=1, sram_wmode=req_write, sram_addr=req_addr, sram_wdata=req_wdata combinationally in the same cycle; otherwise sram_en=0.
REQ-020 Read latency SHALL be 1: in the cycle after an accepted read, resp_valid=1 and resp_rdata=sram_rdata (bypass path).
REQ-021 If that response is not accepted, the block SHALL capture sram_rdata into a hold register at the clock edge, then present resp_valid=1 and resp_rdata=hold until resp_ready.
REQ-022 At most one read response SHALL be outstanding; a read issued in the same cycle its predecessor's response is accepted SHALL be allowed (back-to-back reads at full rate).
REQ-023 A write accepted while a response is pending or held SHALL NOT alter the returned data, even to the same address (old data is returned).
REQ-024 A read following a write to the same address in the next cycle SHALL return the new data.
REQ-025 sram_rdata SHALL be ignored in any cycle not directly following a read enable.
REQ-026 resp_valid, once high, SHALL remain high with stable resp_rdata until resp_ready.

Reset
REQ-027 Asserting reset_n low at any time, including mid-sweep or with a response pending, SHALL immediately force: state=INIT, counter=0, init_done=0, resp_valid=0, req_ready=0, sram_en=0, hold register=0. The pending response SHALL be dropped.
REQ-028 After reset_n is released, the sweep SHALL restart from address 0.

Structure
REQ-029 A shared package SHALL hold the state enum (INIT, RUN) and the default DEPTH/WIDTH/AW constants.
REQ-030 The response path (pending flag, hold register, valid/ready logic) SHALL be a sub-module named sram_resp_buf; the FSM and the request mux SHALL be in the top module.

Verification
REQ-031 Reset release, no traffic -> init_done rises exactly 8192 cycles later; sram_en=sram_wmode=1 with addresses 0..8191 in order; all reads afterwards return 0.
REQ-032 Write 0xDEADBEEF_00000001 to addr 5, read addr 5 the next cycle with resp_ready=1 -> resp_valid the following cycle with data 0xDEADBEEF_00000001.
REQ-033 Read addr 5, resp_ready=0 for 4 cycles, write 0x1234 to addr 5 during the stall -> resp_rdata stays 0xDEADBEEF_00000001 throughout; reads are blocked (req_ready=0) and the write is accepted.
REQ-034 Continuous reads of addrs 0..15 with resp_ready=1 -> one response per cycle, in order, with no bubbles.
REQ-035 reset_n pulsed low at sweep address 3000 and with a held response -> outputs at reset values immediately; the sweep restarts at 0, and init_done follows 8192 cycles after release.
